// File: rtl/iob_axi_m_axis_m_read_int_pkg.sv
// Shared FSM encodings and AXI constants for the AXI-read to AXIS engine.
package iob_axi_m_axis_m_read_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_BUF  = 4'd2;

  localparam int BOUNDARY_4K = 4096;
  localparam int WORDS_4K    = BOUNDARY_4K / 4;

endpackage

// File: rtl/iob_axis_skid_buf.sv
// 2-entry FIFO-ordered skid buffer carrying {last,data}; push to head-valid is 1 cycle.
// Push and pop in one cycle are both honoured; room_nxt lets the producer register its ready.
module iob_axis_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_n_i,
  input  logic              in_vld,
  input  logic [DATA_W:0]   in_dat,
  output logic              out_vld,
  output logic [DATA_W:0]   out_dat,
  input  logic              out_rdy,
  output logic              room_nxt
);

  logic [DATA_W:0] ent0;
  logic [DATA_W:0] ent1;
  logic [1:0]      cnt;
  logic [1:0]      cnt_nxt;
  logic            push;
  logic            pop;

  assign out_vld  = (cnt != 2'd0);
  assign out_dat  = ent0;
  assign pop      = out_vld & out_rdy;
  assign push     = in_vld & (cnt != 2'd2);
  assign cnt_nxt  = cnt + 2'(push) - 2'(pop);
  assign room_nxt = (cnt_nxt != 2'd2);

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        cnt  <= 2'd0;
        ent0 <= '0;
        ent1 <= '0;
      end else begin
        cnt <= cnt_nxt;
        case ({push, pop})
          2'b10: begin
            if (cnt == 2'd0) ent0 <= in_dat;
            else             ent1 <= in_dat;
          end
          2'b01: ent0 <= ent1;
          2'b11: begin
            // With one entry the incoming word becomes the new head directly.
            if (cnt == 2'd1) begin
              ent0 <= in_dat;
            end else begin
              ent0 <= ent1;
              ent1 <= in_dat;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/iob_axi_m_axis_m_read_int.sv
// AXI4 read engine: start -> one or two INCR bursts split at 4 KiB, data forwarded to AXIS.
// Start -> arvalid 1 cycle, R -> AXIS 1 cycle; rready is registered from skid buffer room.
module iob_axi_m_axis_m_read_int
  import iob_axi_m_axis_m_read_int_pkg::*;
#(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_n_i,
  input  logic                  r_start_transfer_i,
  input  logic [AXI_ADDR_W-1:0] r_addr_i,
  input  logic [AXI_LEN_W:0]    r_length_i,
  output logic                  r_busy_o,
  output logic                  r_error_o,
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o,
  output logic [AXI_DATA_W-1:0] axis_out_data_o,
  output logic                  axis_out_valid_o,
  output logic                  axis_out_last_o,
  input  logic                  axis_out_ready_i
);

  localparam int LW1 = AXI_LEN_W + 1;
  localparam int WW  = (LW1 > 11) ? LW1 : 11;

  state_t                state;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [AXI_LEN_W-1:0]  arlen_q;
  logic [AXI_LEN_W:0]    remaining_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  error_q;

  logic [WW-1:0]         w_to_bnd;
  logic [WW-1:0]         len_w;
  logic                  crosses;
  logic                  r_hs;
  logic                  r_final;
  logic                  data_nxt;
  logic                  buf_vld;
  logic [AXI_DATA_W:0]   buf_dat;
  logic                  buf_room_nxt;

  // Words left before the next 4 KiB boundary; the transfer crosses it exactly
  // when bit 12 of its last byte address differs from that of its first.
  assign w_to_bnd = WW'(WORDS_4K) - WW'(r_addr_i[11:2]);
  assign len_w    = WW'(r_length_i);
  assign crosses  = (len_w > w_to_bnd);

  assign r_hs     = axi_rvalid_i & rready_q;
  assign r_final  = (remaining_q == '0) & axi_rlast_i;
  assign data_nxt = ((state == ST_ADDR) & axi_arready_i) |
                    ((state == ST_DATA) & ~(r_hs & axi_rlast_i));

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        state       <= ST_IDLE;
        araddr_q    <= '0;
        arlen_q     <= '0;
        remaining_q <= '0;
        arvalid_q   <= 1'b0;
        rready_q    <= 1'b0;
        error_q     <= 1'b0;
      end else begin
        rready_q <= data_nxt & buf_room_nxt;
        case (state)
          ST_IDLE: begin
            if (r_start_transfer_i && (r_length_i != '0)) begin
              araddr_q  <= r_addr_i;
              arvalid_q <= 1'b1;
              error_q   <= 1'b0;
              state     <= ST_ADDR;
              if (crosses) begin
                arlen_q     <= AXI_LEN_W'(w_to_bnd - WW'(1));
                remaining_q <= LW1'(len_w - w_to_bnd);
              end else begin
                arlen_q     <= AXI_LEN_W'(len_w - WW'(1));
                remaining_q <= '0;
              end
            end
          end
          ST_ADDR: begin
            if (axi_arready_i) begin
              arvalid_q <= 1'b0;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (r_hs && (axi_rresp_i != 2'b00)) error_q <= 1'b1;
            if (r_hs && axi_rlast_i) begin
              if (remaining_q == '0) begin
                state <= ST_IDLE;
              end else begin
                araddr_q    <= araddr_q + ((AXI_ADDR_W'(arlen_q) + AXI_ADDR_W'(1)) << 2);
                arlen_q     <= AXI_LEN_W'(remaining_q - LW1'(1));
                remaining_q <= '0;
                arvalid_q   <= 1'b1;
                state       <= ST_ADDR;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  iob_axis_skid_buf #(
    .DATA_W (AXI_DATA_W)
  ) u_skid (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .rst_n_i  (rst_n_i),
    .in_vld   (r_hs),
    .in_dat   ({r_final, axi_rdata_i}),
    .out_vld  (buf_vld),
    .out_dat  (buf_dat),
    .out_rdy  (axis_out_ready_i),
    .room_nxt (buf_room_nxt)
  );

  assign axis_out_valid_o = buf_vld;
  assign axis_out_data_o  = buf_dat[AXI_DATA_W-1:0];
  assign axis_out_last_o  = buf_vld & buf_dat[AXI_DATA_W];

  assign r_busy_o      = (state != ST_IDLE) | buf_vld;
  assign r_error_o     = error_q;
  assign axi_arid_o    = '0;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = SIZE_4B;
  assign axi_arburst_o = BURST_INCR;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = CACHE_BUF;
  assign axi_arqos_o   = 4'd0;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_iob_axi_m_axis_m_read_int.sv
// Scoreboard bench: an AXI slave model serves AR bursts, expected ARs and AXIS beats are queued at start.
module tb_iob_axi_m_axis_m_read_int;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int IW = 1;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          cke_i;
  logic          rst_n_i;
  logic          r_start_transfer_i;
  logic [AW-1:0] r_addr_i;
  logic [LW:0]   r_length_i;
  logic          r_busy_o;
  logic          r_error_o;
  logic [IW-1:0] axi_arid_o;
  logic [AW-1:0] axi_araddr_o;
  logic [LW-1:0] axi_arlen_o;
  logic [2:0]    axi_arsize_o;
  logic [1:0]    axi_arburst_o;
  logic [1:0]    axi_arlock_o;
  logic [3:0]    axi_arcache_o;
  logic [3:0]    axi_arqos_o;
  logic          axi_arvalid_o;
  logic          axi_arready_i;
  logic [DW-1:0] axi_rdata_i;
  logic [1:0]    axi_rresp_i;
  logic          axi_rlast_i;
  logic          axi_rvalid_i;
  logic          axi_rready_o;
  logic [DW-1:0] axis_out_data_o;
  logic          axis_out_valid_o;
  logic          axis_out_last_o;
  logic          axis_out_ready_i;

  iob_axi_m_axis_m_read_int #(
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (DW),
    .AXI_LEN_W  (LW),
    .AXI_ID_W   (IW)
  ) dut (
    .clk_i              (clk_i),
    .cke_i              (cke_i),
    .rst_n_i            (rst_n_i),
    .r_start_transfer_i (r_start_transfer_i),
    .r_addr_i           (r_addr_i),
    .r_length_i         (r_length_i),
    .r_busy_o           (r_busy_o),
    .r_error_o          (r_error_o),
    .axi_arid_o         (axi_arid_o),
    .axi_araddr_o       (axi_araddr_o),
    .axi_arlen_o        (axi_arlen_o),
    .axi_arsize_o       (axi_arsize_o),
    .axi_arburst_o      (axi_arburst_o),
    .axi_arlock_o       (axi_arlock_o),
    .axi_arcache_o      (axi_arcache_o),
    .axi_arqos_o        (axi_arqos_o),
    .axi_arvalid_o      (axi_arvalid_o),
    .axi_arready_i      (axi_arready_i),
    .axi_rdata_i        (axi_rdata_i),
    .axi_rresp_i        (axi_rresp_i),
    .axi_rlast_i        (axi_rlast_i),
    .axi_rvalid_i       (axi_rvalid_i),
    .axi_rready_o       (axi_rready_o),
    .axis_out_data_o    (axis_out_data_o),
    .axis_out_valid_o   (axis_out_valid_o),
    .axis_out_last_o    (axis_out_last_o),
    .axis_out_ready_i   (axis_out_ready_i)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } ar_t;

  ar_t           exp_ar_q[$];
  ar_t           sl_q[$];
  logic [DW:0]   exp_beat_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int sl_idx = 0;
  int tr_beat = 0;
  int err_at = 0;
  int occ = 0;
  int ax_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;
  int full_seen = 0;

  logic          rst_pend;
  logic          start_pend;
  logic [AW-1:0] start_addr;
  logic [LW:0]   start_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_dat(input logic [AW-1:0] a);
    return {8'h5A, a} ^ 32'h0013_5700;
  endfunction

  // Inputs change only at the falling edge, held through the next rising edge.
  task automatic drive();
    rst_n_i            = !rst_pend;
    r_start_transfer_i = start_pend;
    r_addr_i           = start_addr;
    r_length_i         = start_len;
    start_pend         = 1'b0;
    axi_arready_i      = 1'b1;
    axis_out_ready_i   = (ready_mode == 0) || (cyc % 3 == 0);
    if (sl_q.size() != 0) begin
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = beat_dat(sl_q[0].addr + AW'(4 * sl_idx));
      axi_rlast_i  = (sl_idx == int'(sl_q[0].len));
      axi_rresp_i  = (tr_beat + 1 == err_at) ? 2'b10 : 2'b00;
    end else begin
      axi_rvalid_i = 1'b0;
      axi_rdata_i  = '0;
      axi_rlast_i  = 1'b0;
      axi_rresp_i  = 2'b00;
    end
    cyc++;
  endtask

  // Evaluates handshakes that the coming rising edge will complete.
  task automatic monitor();
    ar_t         e;
    logic [DW:0] b;
    if (!rst_n_i) return;
    if (axi_arvalid_o && axi_arready_i) begin
      if (exp_ar_q.size() == 0) begin
        chk("ar_unexpected", 1, 0);
      end else begin
        e = exp_ar_q.pop_front();
        chk("araddr", axi_araddr_o, e.addr);
        chk("arlen", axi_arlen_o, e.len);
        chk("ar_const", {axi_arid_o, axi_arsize_o, axi_arburst_o, axi_arlock_o, axi_arcache_o, axi_arqos_o},
            {1'b0, 3'd2, 2'b01, 2'b00, 4'd2, 4'd0});
      end
      sl_q.push_back('{addr: axi_araddr_o, len: axi_arlen_o});
    end
    if (occ == 2) begin
      full_seen++;
      chk("rready_full", axi_rready_o, 0);
    end
    if (axi_rvalid_i && axi_rready_o) begin
      occ++;
      tr_beat++;
      sl_idx++;
      if (axi_rlast_i) begin
        void'(sl_q.pop_front());
        sl_idx = 0;
      end
    end
    if (axis_out_valid_o && axis_out_ready_i) begin
      occ--;
      ax_cnt++;
      if (exp_beat_q.size() == 0) begin
        chk("axis_unexpected", 1, 0);
      end else begin
        b = exp_beat_q.pop_front();
        chk("axis_dat", axis_out_data_o, b[DW-1:0]);
        chk("axis_last", axis_out_last_o, b[DW]);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    drive();
    #1;
    monitor();
  endtask

  task automatic pulse_start(input int addr, input int len, input bit accept);
    int fw;
    start_pend = 1'b1;
    start_addr = AW'(addr);
    start_len  = (LW+1)'(len);
    if (accept) begin
      tr_beat = 0;
      fw = (4096 - (addr % 4096)) / 4;
      if (len <= fw) begin
        exp_ar_q.push_back('{addr: AW'(addr), len: LW'(len - 1)});
      end else begin
        exp_ar_q.push_back('{addr: AW'(addr), len: LW'(fw - 1)});
        exp_ar_q.push_back('{addr: AW'(addr + fw * 4), len: LW'(len - fw - 1)});
      end
      for (int i = 0; i < len; i++)
        exp_beat_q.push_back({(i == len - 1), beat_dat(AW'(addr + 4 * i))});
    end
    cycle();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_beat_q.size() != 0 || exp_ar_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_beat_q.size() + exp_ar_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    cke_i              = 1'b1;
    rst_pend           = 1'b1;
    start_pend         = 1'b0;
    start_addr         = '0;
    start_len          = '0;
    rst_n_i            = 1'b0;
    r_start_transfer_i = 1'b0;
    r_addr_i           = '0;
    r_length_i         = '0;
    axi_arready_i      = 1'b1;
    axi_rvalid_i       = 1'b0;
    axi_rdata_i        = '0;
    axi_rresp_i        = 2'b00;
    axi_rlast_i        = 1'b0;
    axis_out_ready_i   = 1'b1;

    repeat (3) cycle();
    rst_pend = 1'b0;
    cycle();
    chk("rst_arvalid", axi_arvalid_o, 0);
    chk("rst_rready", axi_rready_o, 0);
    chk("rst_axis_vld", axis_out_valid_o, 0);
    chk("rst_busy", r_busy_o, 0);
    chk("rst_error", r_error_o, 0);

    // Single burst, full throughput.
    pulse_start(32'h100, 16, 1);
    chk("ar_before", axi_arvalid_o, 0);
    cycle();
    chk("ar_latency", axi_arvalid_o, 1);
    chk("busy_on", r_busy_o, 1);
    wait_drain(200);
    chk("busy_at_last", r_busy_o, 1);
    cycle();
    chk("busy_fall", r_busy_o, 0);

    // 4 KiB split into two bursts.
    pulse_start(32'hFF8, 8, 1);
    wait_drain(200);
    repeat (2) cycle();
    chk("split_idle", r_busy_o, 0);

    // AXIS backpressure, ready one cycle in three.
    ready_mode = 1;
    pulse_start(32'h100, 16, 1);
    wait_drain(400);
    ready_mode = 0;
    repeat (2) cycle();
    chk("full_seen", full_seen > 0, 1);
    chk("bp_idle", r_busy_o, 0);

    // Error response on beat 3.
    err_at = 3;
    pulse_start(32'h40, 4, 1);
    wait_drain(200);
    err_at = 0;
    cycle();
    chk("err_set", r_error_o, 1);

    // Zero length and start-while-busy are ignored.
    pulse_start(32'h80, 0, 0);
    repeat (4) cycle();
    chk("len0_busy", r_busy_o, 0);
    chk("len0_no_ar", axi_arvalid_o, 0);
    chk("err_sticky", r_error_o, 1);
    pulse_start(32'h300, 8, 1);
    cycle();
    chk("err_cleared", r_error_o, 0);
    pulse_start(32'h800, 4, 0);
    chk("busy_kept", r_busy_o, 1);
    wait_drain(200);
    repeat (3) cycle();
    chk("ignore_idle", r_busy_o, 0);

    // Reset in the middle of a burst.
    err_at = 2;
    pulse_start(32'h200, 32, 1);
    base = ax_cnt;
    n = 0;
    while (ax_cnt < base + 5 && n < 200) begin
      cycle();
      n++;
    end
    chk("rst_wait", ax_cnt >= base + 5, 1);
    rst_pend = 1'b1;
    cycle();
    exp_ar_q.delete();
    exp_beat_q.delete();
    sl_q.delete();
    sl_idx = 0;
    occ = 0;
    err_at = 0;
    rst_pend = 1'b0;
    cycle();
    chk("mid_arvalid", axi_arvalid_o, 0);
    chk("mid_araddr", axi_araddr_o, 0);
    chk("mid_arlen", axi_arlen_o, 0);
    chk("mid_rready", axi_rready_o, 0);
    chk("mid_axis_vld", axis_out_valid_o, 0);
    chk("mid_axis_last", axis_out_last_o, 0);
    chk("mid_axis_dat", axis_out_data_o, 0);
    chk("mid_busy", r_busy_o, 0);
    chk("mid_error", r_error_o, 0);
    pulse_start(32'h40, 4, 1);
    wait_drain(200);
    repeat (2) cycle();
    chk("post_rst_idle", r_busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
